// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - Shared pipeline word width, NOP encoding and IF/ID entry type
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pc_plus4;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_if.sv
// rtl/if_id_fifo_if.sv - Fetch/decode handshake bundle for the IF/ID buffer
interface if_id_fifo_if
  import riscv_defines::*;
#(
  parameter int DEPTH = 2
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [WORD_WIDTH-1:0] push_instr_i;
  logic [WORD_WIDTH-1:0] push_pc_i;
  logic [WORD_WIDTH-1:0] push_pc_plus4_i;
  logic                  instr_valid_o;
  logic                  id_ready_i;
  logic [WORD_WIDTH-1:0] instr_o;
  logic [WORD_WIDTH-1:0] pc_o;
  logic [WORD_WIDTH-1:0] pc_plus4_o;
  logic                  no_op_flag_o;
  logic [CNT_W-1:0]      count_o;
  logic                  overflow_o;

  // Fetch/decode side that drives pushes, flushes and consumption
  modport master (
    output flush_i, push_valid_i, push_instr_i, push_pc_i, push_pc_plus4_i, id_ready_i,
    input  push_ready_o, instr_valid_o, instr_o, pc_o, pc_plus4_o, no_op_flag_o,
           count_o, overflow_o
  );

  // Buffer side
  modport slave (
    input  flush_i, push_valid_i, push_instr_i, push_pc_i, push_pc_plus4_i, id_ready_i,
    output push_ready_o, instr_valid_o, instr_o, pc_o, pc_plus4_o, no_op_flag_o,
           count_o, overflow_o
  );

endinterface

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - First-word-fall-through IF/ID instruction buffer with flush
module if_id_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  if_id_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  if_id_entry_t     mem [DEPTH];
  if_id_entry_t     head;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             push_ready;
  logic             instr_valid;
  logic             push_fire;
  logic             pop_fire;

  // Ready looks only at occupancy so there is no ID-ready to fetch-ready path
  assign push_ready  = (count != FULL_COUNT);
  assign instr_valid = (count != '0);
  assign push_fire   = bus.push_valid_i && push_ready && !bus.flush_i;
  assign pop_fire    = instr_valid && bus.id_ready_i && !bus.flush_i;
  assign head        = mem[rptr];

  // Pointer, occupancy and sticky overflow bookkeeping; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_fire) wptr <= wptr + 1'b1;
      if (pop_fire)  rptr <= rptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.push_valid_i && !push_ready) overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset so it can map onto plain registers or RAM
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wptr] <= '{instr: bus.push_instr_i, pc: bus.push_pc_i, pc_plus4: bus.push_pc_plus4_i};
    end
  end

  // Head view toward ID, replaced by a NOP bubble while empty
  always_comb begin
    bus.instr_o      = NOP_INSTR;
    bus.pc_o         = '0;
    bus.pc_plus4_o   = '0;
    bus.no_op_flag_o = 1'b1;
    if (instr_valid) begin
      bus.instr_o      = head.instr;
      bus.pc_o         = head.pc;
      bus.pc_plus4_o   = head.pc_plus4;
      bus.no_op_flag_o = 1'b0;
    end
  end

  assign bus.push_ready_o  = push_ready;
  assign bus.instr_valid_o = instr_valid;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop_fire |-> instr_valid);

endmodule

// File: tb/tb_if_id_fifo.sv
// tb/tb_if_id_fifo.sv - Scoreboard bench for the IF/ID instruction buffer
module tb_if_id_fifo;
  import riscv_defines::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] sb_q[$];
  logic        m_ovf = 1'b0;

  if_id_fifo_if #(.DEPTH(DEPTH)) ifc ();

  if_id_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc << 8) | 32'h0000_0033;
  endfunction

  task automatic set_in(input bit fl, input bit pv, input logic [31:0] pc, input bit rdy);
    ifc.flush_i         = fl;
    ifc.push_valid_i    = pv;
    ifc.push_instr_i    = instr_of(pc);
    ifc.push_pc_i       = pc;
    ifc.push_pc_plus4_i = pc + 32'd4;
    ifc.id_ready_i      = rdy;
  endtask

  // Model the edge from the driven inputs, then wait for the next sampling point
  task automatic advance();
    bit full;
    bit popv;
    bit pushv;
    full = (sb_q.size() == DEPTH);
    if (ifc.flush_i) begin
      sb_q.delete();
    end else begin
      popv  = ifc.id_ready_i && (sb_q.size() != 0);
      pushv = ifc.push_valid_i && !full;
      if (ifc.push_valid_i && full) m_ovf = 1'b1;
      if (popv) void'(sb_q.pop_front());
      if (pushv) sb_q.push_back(ifc.push_pc_i);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifc.push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ifc.push_ready_o); end
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifc.instr_valid_o); end
    checks++; if (ifc.instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", ifc.instr_o); end
    checks++; if (ifc.pc_o !== 32'h0 || ifc.pc_plus4_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h expected 0/0", ifc.pc_o, ifc.pc_plus4_o); end
    checks++; if (ifc.no_op_flag_o !== 1'b1) begin errors++; $display("FAIL reset_noop: got %b expected 1", ifc.no_op_flag_o); end
    checks++; if (ifc.count_o !== '0 || ifc.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_count_ovf: got %0d/%b expected 0/0", ifc.count_o, ifc.overflow_o); end
  endtask

  task automatic test_in_order();
    set_in(0, 1, 32'h100, 1);
    checks++; if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", ifc.instr_valid_o); end
    advance();
    set_in(0, 1, 32'h104, 1);
    checks++; if (ifc.pc_o !== 32'h100 || ifc.instr_o !== instr_of(32'h100) || ifc.pc_plus4_o !== 32'h104) begin
      errors++; $display("FAIL order_first: got %h/%h/%h expected 100/%h/104", ifc.pc_o, ifc.instr_o, ifc.pc_plus4_o, instr_of(32'h100)); end
    checks++; if (ifc.no_op_flag_o !== 1'b0) begin errors++; $display("FAIL order_noop1: got %b expected 0", ifc.no_op_flag_o); end
    advance();
    set_in(0, 0, 32'h0, 1);
    checks++; if (ifc.pc_o !== 32'h104 || ifc.instr_valid_o !== 1'b1) begin errors++; $display("FAIL order_second: got %h/%b expected 104/1", ifc.pc_o, ifc.instr_valid_o); end
    checks++; if (ifc.no_op_flag_o !== 1'b0) begin errors++; $display("FAIL order_noop2: got %b expected 0", ifc.no_op_flag_o); end
    advance();
    set_in(0, 0, 32'h0, 0);
    checks++; if (ifc.no_op_flag_o !== 1'b1 || ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL order_drained: got %b/%b expected 1/0", ifc.no_op_flag_o, ifc.instr_valid_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    set_in(0, 1, 32'h0, 1);
    advance();
    for (int i = 1; i <= 20; i++) begin
      set_in(0, 1, 32'(4 * i), 1);
      exp_pc = (sb_q.size() != 0) ? sb_q[0] : 32'hFFFF_FFFF;
      checks++; if (ifc.count_o !== CW'(1)) begin errors++; $display("FAIL stream_count cycle %0d: got %0d expected 1", i, ifc.count_o); end
      checks++; if (ifc.pc_o !== exp_pc || exp_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc cycle %0d: got %h expected %h", i, ifc.pc_o, 32'(4 * (i - 1))); end
      checks++; if (ifc.instr_o !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_instr cycle %0d: got %h expected %h", i, ifc.instr_o, instr_of(exp_pc)); end
      advance();
    end
    set_in(0, 0, 32'h0, 1);
    advance();
    set_in(0, 0, 32'h0, 0);
    checks++; if (ifc.count_o !== '0) begin errors++; $display("FAIL stream_drain: got %0d expected 0", ifc.count_o); end
  endtask

  task automatic test_flush();
    set_in(0, 1, 32'h200, 0); advance();
    set_in(0, 1, 32'h204, 0); advance();
    checks++; if (ifc.count_o !== CW'(2) || ifc.push_ready_o !== 1'b0) begin errors++; $display("FAIL flush_full: got %0d/%b expected 2/0", ifc.count_o, ifc.push_ready_o); end
    set_in(1, 1, 32'h208, 1); advance();
    set_in(0, 0, 32'h0, 0);
    checks++; if (ifc.count_o !== '0 || ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL flush_count: got %0d/%b expected 0/0", ifc.count_o, ifc.instr_valid_o); end
    checks++; if (ifc.instr_o !== NOP_INSTR || ifc.pc_o !== 32'h0) begin errors++; $display("FAIL flush_outputs: got %h/%h expected 00000013/0", ifc.instr_o, ifc.pc_o); end
    checks++; if (ifc.overflow_o !== m_ovf) begin errors++; $display("FAIL flush_overflow: got %b expected %b", ifc.overflow_o, m_ovf); end
    set_in(0, 1, 32'h300, 0); advance();
    checks++; if (ifc.count_o !== CW'(1) || ifc.pc_o !== 32'h300) begin errors++; $display("FAIL flush_repush: got %0d/%h expected 1/300", ifc.count_o, ifc.pc_o); end
    set_in(0, 0, 32'h0, 1); advance();
  endtask

  task automatic test_overflow();
    set_in(0, 1, 32'h400, 0); advance();
    checks++; if (ifc.count_o !== CW'(1) || ifc.push_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_one: got %0d/%b expected 1/1", ifc.count_o, ifc.push_ready_o); end
    set_in(0, 1, 32'h404, 0); advance();
    checks++; if (ifc.count_o !== CW'(2) || ifc.push_ready_o !== 1'b0 || ifc.overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_two: got %0d/%b/%b expected 2/0/0", ifc.count_o, ifc.push_ready_o, ifc.overflow_o); end
    set_in(0, 1, 32'h408, 1); advance();
    checks++; if (ifc.overflow_o !== 1'b1 || ifc.count_o !== CW'(1) || ifc.pc_o !== 32'h404) begin
      errors++; $display("FAIL ovf_drop: got %b/%0d/%h expected 1/1/404", ifc.overflow_o, ifc.count_o, ifc.pc_o); end
    set_in(0, 0, 32'h0, 1);
    checks++; if (sb_q.size() != 1 || ifc.pc_o !== sb_q[0]) begin errors++; $display("FAIL ovf_sb: got %h expected one entry 404", ifc.pc_o); end
    advance();
    set_in(0, 0, 32'h0, 0);
    checks++; if (ifc.instr_valid_o !== 1'b0 || ifc.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b/%b expected 0/1", ifc.instr_valid_o, ifc.overflow_o); end
  endtask

  task automatic test_async_reset();
    set_in(0, 1, 32'h500, 0); advance();
    set_in(0, 1, 32'h504, 0); advance();
    set_in(0, 0, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.instr_valid_o !== 1'b0 || ifc.count_o !== '0) begin errors++; $display("FAIL areset_clear: got %b/%0d expected 0/0", ifc.instr_valid_o, ifc.count_o); end
    checks++; if (ifc.instr_o !== NOP_INSTR || ifc.overflow_o !== 1'b0 || ifc.push_ready_o !== 1'b1) begin
      errors++; $display("FAIL areset_outputs: got %h/%b/%b expected 00000013/0/1", ifc.instr_o, ifc.overflow_o, ifc.push_ready_o); end
    #1 rst_n = 1'b1;
    sb_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    set_in(0, 1, 32'h600, 0); advance();
    checks++; if (ifc.instr_valid_o !== 1'b1 || ifc.pc_o !== 32'h600 || ifc.instr_o !== instr_of(32'h600) || ifc.pc_plus4_o !== 32'h604) begin
      errors++; $display("FAIL areset_repush: got %b/%h/%h/%h expected 1/600/%h/604", ifc.instr_valid_o, ifc.pc_o, ifc.instr_o, ifc.pc_plus4_o, instr_of(32'h600)); end
    set_in(0, 0, 32'h0, 1); advance();
  endtask

  task automatic test_random();
    logic [31:0] next_pc;
    int          sz;
    next_pc = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      set_in(($urandom % 20) == 0, ($urandom % 4) != 0, next_pc, ($urandom % 3) != 0);
      next_pc = next_pc + 32'd4;
      sz = sb_q.size();
      checks++; if (ifc.count_o !== CW'(sz) || ifc.instr_valid_o !== (sz != 0)) begin
        errors++; $display("FAIL rnd_count cycle %0d: got %0d/%b expected %0d/%b", c, ifc.count_o, ifc.instr_valid_o, sz, sz != 0); end
      checks++; if (ifc.push_ready_o !== (sz != DEPTH) || ifc.no_op_flag_o !== (sz == 0)) begin
        errors++; $display("FAIL rnd_flags cycle %0d: got %b/%b expected %b/%b", c, ifc.push_ready_o, ifc.no_op_flag_o, sz != DEPTH, sz == 0); end
      checks++; if (ifc.overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_overflow cycle %0d: got %b expected %b", c, ifc.overflow_o, m_ovf); end
      if (sz != 0) begin
        checks++; if (ifc.pc_o !== sb_q[0] || ifc.instr_o !== instr_of(sb_q[0]) || ifc.pc_plus4_o !== sb_q[0] + 32'd4) begin
          errors++; $display("FAIL rnd_head cycle %0d: got %h/%h expected pc %h", c, ifc.pc_o, ifc.instr_o, sb_q[0]); end
      end else begin
        checks++; if (ifc.instr_o !== NOP_INSTR || ifc.pc_o !== 32'h0) begin errors++; $display("FAIL rnd_empty cycle %0d: got %h/%h expected 00000013/0", c, ifc.instr_o, ifc.pc_o); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_streaming();
    test_flush();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

First-word-fall-through instruction buffer between the fetch stage and the decode stage. It captures each instruction returned by instruction memory, together with its PC and PC+4. It presents the oldest entry to ID under a valid/ready handshake and discards everything in flight on a taken branch or jump. It decouples memory return latency from ID stalls and supplies a NOP bubble whenever it is empty.

## Interface
- WORD_WIDTH, 32, width of instruction, PC and PC+4
- DEPTH, 2, number of entries; power of two, at least 2
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush_i  input  1  taken branch/jump; empties buffer at next edge
- push_valid_i  input  1  instruction word valid (memory rvalid)
- push_ready_o  output  1  buffer can accept a push this cycle
- push_instr_i  input  WORD_WIDTH  instruction word
- push_pc_i  input  WORD_WIDTH  PC of the instruction
- push_pc_plus4_i  input  WORD_WIDTH  PC+4 of the instruction
- instr_valid_o  output  1  head entry valid toward ID
- id_ready_i  input  1  ID consumes head this cycle
- instr_o  output  WORD_WIDTH  head instruction, or NOP when empty
- pc_o  output  WORD_WIDTH  head PC, or 0 when empty
- pc_plus4_o  output  WORD_WIDTH  head PC+4, or 0 when empty
- no_op_flag_o  output  1  high when empty, so ID inserts a bubble
- count_o  output  $clog2(DEPTH+1)  occupied entries
- overflow_o  output  1  sticky: a push was presented while not ready

## Operation
- Storage: DEPTH entries of {instr, pc, pc_plus4}, plus read pointer, write pointer and count registers. Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Push fires when push_valid_i && push_ready_o: the entry is written at wptr, and wptr advances.
- push_ready_o = (count != DEPTH). It does not depend on id_ready_i, so there is no combinational ready-to-ready path. When full, a push is refused even if a pop occurs in the same cycle.
- Pop fires when instr_valid_o && id_ready_i: rptr advances.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- instr_valid_o = (count != 0). Head outputs are combinational from the entry at rptr.
- Empty: instr_o = NOP_INSTR (32'h0000_0013), pc_o = 0, pc_plus4_o = 0, no_op_flag_o = 1.
- Flush has priority over push and pop. At the next edge, count = 0 and rptr = wptr = 0. A push presented in the flush cycle is discarded and does not set overflow_o. Pop is ignored in the flush cycle.
- Overflow: push_valid_i && !push_ready_o && !flush_i sets overflow_o. The word is dropped and buffer state is unchanged. The flag clears only on reset.
- Reset (asynchronous, immediate): count = 0, pointers = 0, overflow_o = 0. Outputs then show the empty values: push_ready_o = 1, instr_valid_o = 0, NOP on instr_o. Storage contents are not reset.

## Timing
- Push-to-visible latency is 1 cycle. A push at edge N makes instr_valid_o high and the data visible from edge N onward, with no combinational push-to-output path.
- Pop takes effect at the edge. The next entry appears in the following cycle with no bubble if count was at least 2.
- Sustained throughput is 1 instruction/cycle with simultaneous push and pop at any count from 1 to DEPTH-1.
- Flush at edge N: outputs are empty from N onward, and the first post-flush push can land at edge N+1.
- Reset asserted mid-operation: all in-flight entries are lost, and outputs go to the empty values asynchronously.
- No state machine. Occupancy states are EMPTY (count 0), PARTIAL and FULL (count DEPTH), all derived from count.

## Structure
- Shared package riscv_defines holds WORD_WIDTH and NOP_INSTR = 32'h0000_0013, plus a packed struct if_id_entry_t {instr, pc, pc_plus4} reused by ID.
- Single module, no sub-modules. Storage is an array of if_id_entry_t.
- Assertions (simulation only): count never exceeds DEPTH; pop never occurs when empty.

## Test plan
- Reset, then 3 pushes with id_ready_i = 0 (DEPTH = 2): count_o = 2, push_ready_o = 0 after the second push, third word dropped, overflow_o = 1.
- Push pc = 0x100 then 0x104 with id_ready_i = 1: ID sees 0x100 then 0x104 on consecutive cycles, and no_op_flag_o = 0 while non-empty.
- Continuous push and pop for 20 cycles with PCs 0x0, 0x4, and so on: outputs in order, count_o stays at 1, pointers wrap correctly.
- Full buffer plus flush_i with a simultaneous push: next cycle count_o = 0, instr_o = 0x00000013, pc_o = 0, overflow_o unchanged.
- rst_n pulsed low mid-stream: asynchronous clear with instr_valid_o = 0 before the next edge, and the first post-reset push appears correctly.
- Random valid/ready/flush for 10k cycles against a scoreboard: order preserved, no loss except flush or overflow drops.
